// File: rtl/alloc_pkg.sv
// Shared types and defaults for the wormhole switch allocator.
package alloc_pkg;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} out_state_t;
  localparam int CREDITS_DEFAULT = 4;
endpackage

// File: rtl/alloc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer; the pointer
// moves past the winner only when i_update is asserted.
module alloc_rr_arbiter #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:N-1] i_request,
  input  logic         i_update,
  output logic [0:N-1] o_grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d, win;
  logic          found;
  int            idx;

  always_comb begin
    o_grant = '0;
    found   = 1'b0;
    win     = '0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && i_request[idx]) begin
        o_grant[idx] = 1'b1;
        found        = 1'b1;
        win          = PW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (i_update && found)
      ptr_d = (win == PW'(N - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/config.sv
// Build-wide port-count defaults shared by the router blocks.
`ifndef N
`define N 5
`endif
`ifndef M
`define M 5
`endif

// File: rtl/switch_allocator_wh.sv
// Wormhole switch allocator: per-output packet lock FSM, round-robin head
// arbitration and downstream credit counters; grants are combinational.
`ifndef N
`define N 5
`endif
`ifndef M
`define M 5
`endif

module switch_allocator_wh
  import alloc_pkg::*;
#(
  parameter int N       = `N,
  parameter int M       = `M,
  parameter int CREDITS = CREDITS_DEFAULT,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic [0:N-1][0:M-1]    i_output_req,
  input  logic [0:N-1]           i_tail,
  input  logic [0:M-1]           i_credit_return,
  output logic [0:M-1][0:N-1]    o_output_grant,
  output logic [0:N-1]           o_input_grant,
  output logic [0:M-1]           o_lock,
  output logic [0:M-1][CW-1:0]   o_credit_count,
  output logic                   o_err
);
  localparam int            PW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  logic                   active;
  logic [0:N-1]           multi;
  logic [0:M-1][0:N-1]    req_col, arb_req, arb_gnt, gnt;
  logic [0:M-1]           ovf;
  logic                   err_q, err_d;

  assign active = ce & ~reset;

  // A multi-hot word is dropped from every output's view for that cycle.
  always_comb begin
    multi   = '0;
    req_col = '0;
    for (int j = 0; j < N; j++) begin
      multi[j] = ($countones(i_output_req[j]) > 1);
      for (int i = 0; i < M; i++)
        req_col[i][j] = i_output_req[j][i] & ~multi[j];
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_out
    out_state_t    state_q, state_d;
    logic [PW-1:0] owner_q, owner_d, win;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [0:N-1]  gnt_w;
    logic          credit_ok, granted, gnt_tail, ovf_w;

    assign credit_ok  = (cnt_q != '0);
    assign arb_req[i] = (active && state_q == IDLE && credit_ok) ? req_col[i] : '0;

    alloc_rr_arbiter #(.N(N)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .i_request (arb_req[i]),
      .i_update  (granted && state_q == IDLE),
      .o_grant   (arb_gnt[i])
    );

    always_comb begin
      gnt_w = '0;
      if (active && credit_ok) begin
        if (state_q == IDLE)            gnt_w = arb_gnt[i];
        else if (req_col[i][owner_q])   gnt_w[owner_q] = 1'b1;
      end
    end

    always_comb begin
      win = '0;
      for (int j = 0; j < N; j++)
        if (gnt_w[j]) win = PW'(j);
    end

    assign granted  = |gnt_w;
    assign gnt_tail = |(gnt_w & i_tail);
    assign gnt[i]   = gnt_w;

    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      ovf_w   = 1'b0;
      if (granted) begin
        case (state_q)
          IDLE:    if (!gnt_tail) begin
                     state_d = LOCKED;
                     owner_d = win;
                   end
          LOCKED:  if (gnt_tail) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
      // Grant and return in the same cycle cancel out.
      if (active) begin
        if (i_credit_return[i] && !granted) begin
          if (cnt_q == CMAX) ovf_w = 1'b1;
          else               cnt_d = cnt_q + 1'b1;
        end else if (granted && !i_credit_return[i]) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        owner_q <= '0;
        cnt_q   <= CMAX;
      end else if (ce) begin
        state_q <= state_d;
        owner_q <= owner_d;
        cnt_q   <= cnt_d;
      end
    end

    assign ovf[i]            = ovf_w;
    assign o_lock[i]         = (state_q == LOCKED);
    assign o_credit_count[i] = cnt_q;
  end

  always_comb begin
    o_input_grant = '0;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < M; i++)
        o_input_grant[j] = o_input_grant[j] | gnt[i][j];
  end

  assign o_output_grant = gnt;

  assign err_d = err_q | (active & ((|ovf) | (|multi)));

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign o_err = err_q;
endmodule

// File: tb/tb_switch_allocator_wh.sv
// Directed bench for switch_allocator_wh with N=M=5, CREDITS=4.
module tb_switch_allocator_wh;
  logic             clk = 1'b0;
  logic             reset, ce;
  logic [0:4][0:4]  req;
  logic [0:4]       tail, ret;
  logic [0:4][0:4]  og;
  logic [0:4]       ig, lock;
  logic [0:4][2:0]  cc;
  logic             err;
  logic [0:4][2:0]  all4;
  int               errors = 0;
  int               checks = 0;

  always #5 clk = ~clk;

  switch_allocator_wh #(.N(5), .M(5), .CREDITS(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .ce              (ce),
    .i_output_req    (req),
    .i_tail          (tail),
    .i_credit_return (ret),
    .o_output_grant  (og),
    .o_input_grant   (ig),
    .o_lock          (lock),
    .o_credit_count  (cc),
    .o_err           (err)
  );

  function automatic logic [0:4] oh(input int k);
    logic [0:4] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic clr();
    req  = '0;
    tail = '0;
    ret  = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; clr();
    req[0] = oh(0); tail[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (og !== '0) begin errors++; $display("FAIL reset_grant: got %h want 0", og); end
    next_cycle();
    reset = 1'b0; clr();
    @(negedge clk);
    checks++;
    if (lock !== 5'b0 || err !== 1'b0 || cc !== all4) begin
      errors++; $display("FAIL reset_state: lock=%b err=%b cc=%h want lock=0 err=0 cc=%h", lock, err, cc, all4);
    end
    next_cycle();
  endtask

  task automatic test_packet_lock();
    int exp_in [5] = '{1, 1, 1, 1, 2};
    logic exp_lk [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 5; c++) begin
      clr();
      if (c < 4) begin req[1] = oh(3); tail[1] = (c == 3); end
      req[2] = oh(3); tail[2] = 1'b1; ret[3] = 1'b1;
      @(negedge clk);
      checks++;
      if (og[3] !== oh(exp_in[c]) || lock[3] !== exp_lk[c]) begin
        errors++; $display("FAIL packet_lock c%0d: grant=%b lock=%b want grant=%b lock=%b", c, og[3], lock[3], oh(exp_in[c]), exp_lk[c]);
      end
      if (c == 4) begin
        checks++;
        if (ig !== oh(2)) begin errors++; $display("FAIL packet_input_grant: got %b want %b", ig, oh(2)); end
      end
      next_cycle();
    end
    clr();
    @(negedge clk);
    checks++;
    if (cc[3] !== 3'd4 || lock[3] !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL packet_after: cc=%0d lock=%b err=%b want 4 0 0", cc[3], lock[3], err);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    int exp_w [4] = '{0, 2, 4, 0};
    for (int c = 0; c < 6; c++) begin
      clr();
      req[0] = oh(0); req[2] = oh(0); req[4] = oh(0);
      tail = 5'b11111;
      @(negedge clk);
      checks++;
      if (c < 4) begin
        if (og[0] !== oh(exp_w[c]) || cc[0] !== 3'(4 - c)) begin
          errors++; $display("FAIL rr c%0d: grant=%b cc=%0d want %b %0d", c, og[0], cc[0], oh(exp_w[c]), 4 - c);
        end
      end else begin
        if (og[0] !== 5'b0 || cc[0] !== 3'd0) begin
          errors++; $display("FAIL rr_empty c%0d: grant=%b cc=%0d want 0 0", c, og[0], cc[0]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_credits();
    for (int c = 0; c < 4; c++) begin
      clr(); req[3] = oh(2); tail[3] = 1'b1;
      @(negedge clk);
      checks++;
      if (og[2] !== oh(3)) begin errors++; $display("FAIL credit_drain c%0d: got %b want %b", c, og[2], oh(3)); end
      next_cycle();
    end
    clr(); req[3] = oh(2); tail[3] = 1'b1; ret[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (og[2] !== 5'b0 || cc[2] !== 3'd0) begin
      errors++; $display("FAIL credit_t: grant=%b cc=%0d want 0 0", og[2], cc[2]);
    end
    next_cycle();
    ret = '0;
    @(negedge clk);
    checks++;
    if (og[2] !== oh(3) || cc[2] !== 3'd1) begin
      errors++; $display("FAIL credit_t1: grant=%b cc=%0d want %b 1", og[2], cc[2], oh(3));
    end
    next_cycle();
    clr(); ret[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (cc[2] !== 3'd0) begin errors++; $display("FAIL credit_back0: cc=%0d want 0", cc[2]); end
    next_cycle();
    clr(); req[3] = oh(2); tail[3] = 1'b1; ret[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (og[2] !== oh(3) || cc[2] !== 3'd1) begin
      errors++; $display("FAIL credit_simul: grant=%b cc=%0d want %b 1", og[2], cc[2], oh(3));
    end
    next_cycle();
    clr();
    @(negedge clk);
    checks++;
    if (cc[2] !== 3'd1 || err !== 1'b0) begin
      errors++; $display("FAIL credit_hold: cc=%0d err=%b want 1 0", cc[2], err);
    end
    next_cycle();
  endtask

  task automatic test_bubble();
    clr(); req[0] = oh(1); req[4] = oh(1); tail[4] = 1'b1;
    @(negedge clk);
    checks++;
    if (og[1] !== oh(0)) begin errors++; $display("FAIL bubble_head: got %b want %b", og[1], oh(0)); end
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      clr(); req[4] = oh(1); tail[4] = 1'b1;
      @(negedge clk);
      checks++;
      if (og[1] !== 5'b0 || lock[1] !== 1'b1) begin
        errors++; $display("FAIL bubble c%0d: grant=%b lock=%b want 0 1", c, og[1], lock[1]);
      end
      next_cycle();
    end
    clr(); req[0] = oh(1); tail[0] = 1'b1; req[4] = oh(1); tail[4] = 1'b1;
    @(negedge clk);
    checks++;
    if (og[1] !== oh(0) || lock[1] !== 1'b1) begin
      errors++; $display("FAIL bubble_tail: grant=%b lock=%b want %b 1", og[1], lock[1], oh(0));
    end
    next_cycle();
    clr(); req[4] = oh(1); tail[4] = 1'b1;
    @(negedge clk);
    checks++;
    if (og[1] !== oh(4) || lock[1] !== 1'b0) begin
      errors++; $display("FAIL bubble_release: grant=%b lock=%b want %b 0", og[1], lock[1], oh(4));
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) begin
      clr(); req[3] = oh(4);
      @(negedge clk);
      checks++;
      if (og[4] !== oh(3) || lock[4] !== logic'(c == 1)) begin
        errors++; $display("FAIL midpkt c%0d: grant=%b lock=%b want %b %0d", c, og[4], lock[4], oh(3), c);
      end
      next_cycle();
    end
    clr(); reset = 1'b1; req[3] = oh(4); req[0] = oh(4); tail[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (og !== '0) begin errors++; $display("FAIL midpkt_reset_grant: got %h want 0", og); end
    next_cycle();
    reset = 1'b0; clr(); req[0] = oh(4); tail[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (lock !== 5'b0 || cc !== all4 || og[4] !== oh(0) || err !== 1'b0) begin
      errors++; $display("FAIL midpkt_after: lock=%b cc=%h grant=%b err=%b want 0 %h %b 0", lock, cc, og[4], err, all4, oh(0));
    end
    next_cycle();
  endtask

  task automatic test_ce();
    clr(); ce = 1'b0; req[1] = oh(0); tail[1] = 1'b1; ret[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (og !== '0 || ig !== 5'b0) begin errors++; $display("FAIL ce_grant: og=%h ig=%b want 0", og, ig); end
    next_cycle();
    ce = 1'b1; clr();
    @(negedge clk);
    checks++;
    if (cc[0] !== 3'd4 || cc[2] !== 3'd4 || err !== 1'b0) begin
      errors++; $display("FAIL ce_hold: cc0=%0d cc2=%0d err=%b want 4 4 0", cc[0], cc[2], err);
    end
    next_cycle();
  endtask

  task automatic test_overflow();
    clr(); ret[0] = 1'b1;
    next_cycle();
    clr();
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || cc[0] !== 3'd4) begin
      errors++; $display("FAIL overflow: err=%b cc=%0d want 1 4", err, cc[0]);
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err); end
    next_cycle();
  endtask

  task automatic test_error();
    clr(); req[2] = 5'b01100; req[0] = oh(1); tail[0] = 1'b1; tail[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (ig[2] !== 1'b0 || og[2] !== 5'b0 || og[1] !== oh(0)) begin
      errors++; $display("FAIL multihot_grant: ig=%b og1=%b og2=%b want ig[2]=0 og1=%b og2=0", ig, og[1], og[2], oh(0));
    end
    next_cycle();
    clr();
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL multihot_err: got %b want 1", err); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
    next_cycle();
  endtask

  initial begin
    for (int k = 0; k < 5; k++) all4[k] = 3'd4;
    test_reset();
    test_packet_lock();
    test_round_robin();
    test_credits();
    test_bubble();
    test_reset_mid();
    test_ce();
    test_overflow();
    test_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
